// File: rtl/uart_bus_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bus_loader_if
//  Purpose  : Single-word memory/peripheral bus driven by the UART loader
//             (address, byte strobes, write data, read data, ownership flag).
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_bus_loader_if;
  logic        bus_active;   // loader owns the bus, CPU held off
  logic [31:0] bus_addr;     // word address, [1:0] always zero
  logic [3:0]  bus_byte_en;  // write strobes
  logic [31:0] bus_wd;       // write data
  logic [31:0] bus_rd;       // read data, valid one cycle after address

  modport master (
    output bus_active,
    output bus_addr,
    output bus_byte_en,
    output bus_wd,
    input  bus_rd
  );

  modport slave (
    input  bus_active,
    input  bus_addr,
    input  bus_byte_en,
    input  bus_wd,
    output bus_rd
  );
endinterface
`default_nettype wire

// File: rtl/uart_bus_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bus_loader
//  Purpose  : UART (8N1) command initiator. 'W' A3..A0 D3..D0 writes one word
//             and answers 0x06; 'R' A3..A0 reads one word and answers D3..D0;
//             any other opcode answers 0x15. Fields are big-endian.
//  Options  : UART_LOADER_CHECKSUM_EN - packet ends with an 8-bit sum of all
//             preceding bytes; a bad sum answers 0x15 with no bus access.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_bus_loader #(
  parameter int DIVISOR        = 217,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic              clk,
  input  logic              sys_rstn,
  input  logic              uart_rxd,
  output logic              uart_txd,
  output logic              busy,
  uart_bus_loader_if.master bus
);
  localparam int CW = $clog2(DIVISOR + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_BIT_END  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] C_HALF_BIT = CW'(DIVISOR / 2 - 1);
  localparam logic [TW-1:0] C_TMO_END  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    C_OP_WRITE = 8'h57;
  localparam logic [7:0]    C_OP_READ  = 8'h52;
  localparam logic [7:0]    C_ACK      = 8'h06;
  localparam logic [7:0]    C_NAK      = 8'h15;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_ADDR = 3'd1;
  localparam logic [2:0] P_DATA = 3'd2;
  localparam logic [2:0] P_BUS  = 3'd4;
  localparam logic [2:0] P_RESP = 3'd5;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam logic [2:0] P_SUM  = 3'd3;
  localparam logic [2:0] C_AFTER_FIELDS = P_SUM;
`else
  localparam logic [2:0] C_AFTER_FIELDS = P_BUS;
`endif

  // receiver
  logic          rx_meta_q, rx_sync_q, rx_prev_q, rx_valid_q, rx_ferr_q;
  logic [1:0]    rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  // parser / bus
  logic [2:0]    p_state_q, p_state_d;
  logic [7:0]    opcode_q;
  logic [1:0]    byte_cnt_q;
  logic [31:0]   addr_q, wd_q, bus_addr_q, bus_wd_q;
  logic [TW-1:0] tmo_q;
  logic          bus_active_q, bus_phase_q;
  logic [3:0]    bus_byte_en_q;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q;
`endif
  // transmitter
  logic          tx_active_q, txd_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_shift_q;
  logic [31:0]   tx_word_q;
  logic [2:0]    tx_left_q;

  logic          w_is_write, w_tmo, w_resp_load, w_tx_next;
  logic [31:0]   w_addr_full, w_wd_full, w_resp_word;
  logic [2:0]    w_resp_len;

  assign w_is_write  = (opcode_q == C_OP_WRITE);
  assign w_tmo       = (tmo_q == C_TMO_END);
  // The last field byte lands in the same edge that enters P_BUS, so splice it in.
  assign w_addr_full = (p_state_q == P_ADDR) ? {addr_q[23:0], rx_shift_q} : addr_q;
  assign w_wd_full   = (p_state_q == P_DATA) ? {wd_q[23:0], rx_shift_q} : wd_q;
  assign w_resp_load = (p_state_d == P_RESP) && (p_state_q != P_RESP);
  assign w_resp_word = (p_state_q != P_BUS) ? {C_NAK, 24'h0} :
                       w_is_write ? {C_ACK, 24'h0} : bus.bus_rd;
  assign w_resp_len  = (p_state_q == P_BUS && !w_is_write) ? 3'd4 : 3'd1;
  // Next byte starts on the very edge the previous stop bit ends: no idle gap.
  assign w_tx_next   = (tx_left_q != 3'd0) &&
                       (!tx_active_q || (tx_cnt_q == C_BIT_END && tx_bit_q == 4'd9));

  assign uart_txd        = txd_q;
  assign busy            = (p_state_q != P_IDLE) || tx_active_q;
  assign bus.bus_active  = bus_active_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_byte_en = bus_byte_en_q;
  assign bus.bus_wd      = bus_wd_q;

  // RX: synchronise the line, find a start edge, sample each bit at its centre.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_meta_q <= 1'b1; rx_sync_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_state_q <= R_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
      rx_valid_q <= 1'b0; rx_ferr_q <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        R_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_q <= '0; rx_state_q <= R_START;
        end
        R_START: if (rx_cnt_q == C_HALF_BIT) begin
          rx_cnt_q <= '0; rx_bit_q <= '0;
          rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;  // high again: glitch
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        R_DATA: if (rx_cnt_q == C_BIT_END) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        default: if (rx_cnt_q == C_BIT_END) begin
          rx_cnt_q <= '0;
          rx_valid_q <= rx_sync_q;
          rx_ferr_q  <= !rx_sync_q;
          rx_state_q <= R_IDLE;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
      endcase
    end
  end

  // Parser next state: collect fields, abort on framing error or timeout.
  always_comb begin
    p_state_d = p_state_q;
    case (p_state_q)
      P_IDLE: if (rx_valid_q)
        p_state_d = (rx_shift_q == C_OP_WRITE || rx_shift_q == C_OP_READ) ? P_ADDR : P_RESP;
      P_ADDR:
        if (rx_ferr_q || w_tmo) p_state_d = P_IDLE;
        else if (rx_valid_q && byte_cnt_q == 2'd3)
          p_state_d = w_is_write ? P_DATA : C_AFTER_FIELDS;
      P_DATA:
        if (rx_ferr_q || w_tmo) p_state_d = P_IDLE;
        else if (rx_valid_q && byte_cnt_q == 2'd3) p_state_d = C_AFTER_FIELDS;
`ifdef UART_LOADER_CHECKSUM_EN
      P_SUM:
        if (rx_ferr_q || w_tmo) p_state_d = P_IDLE;
        else if (rx_valid_q) p_state_d = (rx_shift_q == sum_q) ? P_BUS : P_RESP;
`endif
      P_BUS:  if (w_is_write || bus_phase_q) p_state_d = P_RESP;
      P_RESP: if (!tx_active_q && tx_left_q == 3'd0) p_state_d = P_IDLE;
      default: p_state_d = P_IDLE;
    endcase
  end

  // Parser state register.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) p_state_q <= P_IDLE;
    else           p_state_q <= p_state_d;
  end

  // Field assembly, inter-byte timeout and bus cycle generation.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      opcode_q <= '0; byte_cnt_q <= '0; addr_q <= '0; wd_q <= '0; tmo_q <= '0;
      bus_active_q <= 1'b0; bus_phase_q <= 1'b0; bus_byte_en_q <= '0;
      bus_addr_q <= '0; bus_wd_q <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      if (rx_valid_q || p_state_q == P_IDLE || p_state_q == P_BUS || p_state_q == P_RESP)
        tmo_q <= '0;
      else if (!w_tmo)
        tmo_q <= tmo_q + 1'b1;

      if (rx_valid_q) begin
        case (p_state_q)
          P_IDLE: begin opcode_q <= rx_shift_q; byte_cnt_q <= '0; end
          P_ADDR: begin addr_q <= w_addr_full; byte_cnt_q <= byte_cnt_q + 2'd1; end
          P_DATA: begin wd_q <= w_wd_full; byte_cnt_q <= byte_cnt_q + 2'd1; end
          default: ;
        endcase
`ifdef UART_LOADER_CHECKSUM_EN
        if (p_state_q == P_IDLE) sum_q <= rx_shift_q;
        else                     sum_q <= sum_q + rx_shift_q;
`endif
      end

      if (p_state_d == P_BUS && p_state_q != P_BUS) begin
        bus_active_q <= 1'b1;
        bus_phase_q  <= 1'b0;
        bus_addr_q   <= w_addr_full & 32'hFFFF_FFFC;
        if (w_is_write) begin
          bus_byte_en_q <= 4'hF;
          bus_wd_q      <= w_wd_full;
        end
      end else if (p_state_q == P_BUS) begin
        bus_phase_q <= 1'b1;
        if (p_state_d != P_BUS) begin
          bus_active_q  <= 1'b0;
          bus_byte_en_q <= 4'h0;
        end
      end
    end
  end

  // TX: serialise the response word MSB byte first, each byte 8N1 LSB first.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      txd_q <= 1'b1; tx_active_q <= 1'b0; tx_cnt_q <= '0; tx_bit_q <= '0;
      tx_shift_q <= '0; tx_word_q <= '0; tx_left_q <= '0;
    end else if (w_resp_load) begin
      tx_word_q <= w_resp_word;
      tx_left_q <= w_resp_len;
    end else if (w_tx_next) begin
      txd_q       <= 1'b0;
      tx_shift_q  <= {1'b1, tx_word_q[31:24]};
      tx_word_q   <= {tx_word_q[23:0], 8'h00};
      tx_left_q   <= tx_left_q - 3'd1;
      tx_active_q <= 1'b1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == C_BIT_END) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_active_q <= 1'b0;
        end else begin
          txd_q      <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_bus_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_bus_loader
//  Purpose  : Self-checking bench for uart_bus_loader: random command packets
//             against a packet-level reference model, plus timeout, framing
//             error, back-to-back TX timing and reset-during-TX scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_bus_loader;
  localparam int DIV = 16;
  localparam int TMO = 3000;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic sys_rstn = 1'b1;
  logic uart_rxd = 1'b1;
  logic uart_txd, busy;

  uart_bus_loader_if bus_if();

  uart_bus_loader #(.DIVISOR(DIV), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .sys_rstn(sys_rstn), .uart_rxd(uart_rxd),
    .uart_txd(uart_txd), .busy(busy), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver on the TX line
  logic [7:0] tx_q[$];
  int         tx_t[$];
  int         stop_bad = 0;
  initial begin : tx_mon
    logic [7:0] b;
    int t;
    forever begin
      @(negedge uart_txd);
      @(negedge clk);
      t = cyc;
      repeat (DIV / 2 - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (DIV) @(negedge clk);
      if (uart_txd !== 1'b1) stop_bad++;
      tx_q.push_back(b);
      tx_t.push_back(t);
    end
  end

  // Bus observer
  logic [63:0] wr_log[$];
  logic [31:0] act_addr[$];
  int act_cyc = 0, en_cyc = 0;
  always @(negedge clk) begin
    if (sys_rstn) begin
      if (bus_if.bus_active) begin
        act_cyc++;
        act_addr.push_back(bus_if.bus_addr);
        if (bus_if.bus_byte_en == 4'hF) wr_log.push_back({bus_if.bus_addr, bus_if.bus_wd});
      end
      if (bus_if.bus_byte_en != 4'h0) en_cyc++;
    end
  end

  // Reference model: expected reply (n bytes, left-aligned word) and bus effect.
  function automatic void model(input byte_q_t pkt, input logic [31:0] rd,
                                output int exp_n, output logic [31:0] exp_word,
                                output bit exp_wr, output bit exp_rd,
                                output logic [31:0] exp_addr, output logic [31:0] exp_wd);
    logic [31:0] a;
    exp_n = 1; exp_word = {8'h15, 24'h0};
    exp_wr = 0; exp_rd = 0; exp_addr = 0; exp_wd = 0;
    if (pkt[0] != 8'h57 && pkt[0] != 8'h52) return;
`ifdef UART_LOADER_CHECKSUM_EN
    begin
      int s = 0;
      for (int i = 0; i < pkt.size() - 1; i++) s += int'(pkt[i]);
      if ((s % 256) != int'(pkt[pkt.size() - 1])) return;
    end
`endif
    a = {pkt[1], pkt[2], pkt[3], pkt[4]};
    exp_addr = a - (a % 4);
    if (pkt[0] == 8'h57) begin
      exp_wr = 1; exp_wd = {pkt[5], pkt[6], pkt[7], pkt[8]}; exp_word = {8'h06, 24'h0};
    end else begin
      exp_rd = 1; exp_n = 4; exp_word = rd;
    end
  endfunction

  function automatic byte_q_t mk_pkt(input logic [7:0] op, input logic [31:0] a,
                                     input logic [31:0] d);
    byte_q_t p;
    p.push_back(op);
    for (int i = 3; i >= 0; i--) p.push_back(a[8*i +: 8]);
    if (op == 8'h57) for (int i = 3; i >= 0; i--) p.push_back(d[8*i +: 8]);
`ifdef UART_LOADER_CHECKSUM_EN
    begin
      logic [7:0] s = 8'h00;
      foreach (p[i]) s = s + p[i];
      p.push_back(s);
    end
`endif
    return p;
  endfunction

  function automatic logic [31:0] pack_tx(input int base, input int n);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < n && base + i < tx_q.size(); i++) w[31 - 8*i -: 8] = tx_q[base + i];
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic exec_pkt(input byte_q_t pkt, output bit done);
    foreach (pkt[i]) begin
      send_byte(pkt[i], 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    done = 0;
    for (int i = 0; i < 80 * DIV; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
    end
    repeat (DIV) @(negedge clk);
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0;
    repeat (4) @(negedge clk);
    sys_rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (uart_txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (bus_if.bus_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", bus_if.bus_active); end
    n_vec++; if (bus_if.bus_byte_en !== 4'h0) begin n_err++; $display("FAIL reset_byte_en: got %h want 0", bus_if.bus_byte_en); end
    n_vec++; if (bus_if.bus_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus_if.bus_addr); end
    n_vec++; if (bus_if.bus_wd !== 32'h0) begin n_err++; $display("FAIL reset_wd: got %h want 0", bus_if.bus_wd); end
  endtask

  task automatic test_write();
    byte_q_t p; bit done, ewr, erd; int en, nb, na, ne, nw;
    logic [31:0] a, d, ew, ea, ed;
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 32'h0000_3000 : $urandom;
      d = (k == 0) ? 32'hDEAD_BEEF : $urandom;
      p = mk_pkt(8'h57, a, d);
      model(p, 32'h0, en, ew, ewr, erd, ea, ed);
      nb = tx_q.size(); na = act_cyc; ne = en_cyc; nw = wr_log.size();
      exec_pkt(p, done);
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL write_done[%0d]: got %0d want 1", k, done); end
      n_vec++; if (tx_q.size() - nb != en) begin n_err++; $display("FAIL write_tx_len[%0d]: got %0d want %0d", k, tx_q.size() - nb, en); end
      n_vec++; if (pack_tx(nb, en) !== ew) begin n_err++; $display("FAIL write_tx[%0d]: got %h want %h", k, pack_tx(nb, en), ew); end
      n_vec++; if (wr_log.size() - nw != 1) begin n_err++; $display("FAIL write_count[%0d]: got %0d want 1", k, wr_log.size() - nw); end
      n_vec++; if (wr_log.size() <= nw || wr_log[nw] !== {ea, ed}) begin
        n_err++; $display("FAIL write_bus[%0d]: got %h want %h", k, (wr_log.size() > nw) ? wr_log[nw] : 64'h0, {ea, ed}); end
      n_vec++; if (act_cyc - na != 1) begin n_err++; $display("FAIL write_active_cycles[%0d]: got %0d want 1", k, act_cyc - na); end
      n_vec++; if (en_cyc - ne != 1) begin n_err++; $display("FAIL write_en_cycles[%0d]: got %0d want 1", k, en_cyc - ne); end
    end
  endtask

  task automatic test_read();
    byte_q_t p; bit done, ewr, erd; int en, nb, na, ne, nw;
    logic [31:0] a, rd, ew, ea, ed;
    for (int k = 0; k < 4; k++) begin
      a  = (k == 0) ? 32'h0000_3001 : $urandom;
      rd = (k == 0) ? 32'h1234_5678 : $urandom;
      bus_if.bus_rd = rd;
      p = mk_pkt(8'h52, a, 32'h0);
      model(p, rd, en, ew, ewr, erd, ea, ed);
      nb = tx_q.size(); na = act_cyc; ne = en_cyc; nw = wr_log.size();
      exec_pkt(p, done);
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL read_done[%0d]: got %0d want 1", k, done); end
      n_vec++; if (tx_q.size() - nb != en) begin n_err++; $display("FAIL read_tx_len[%0d]: got %0d want %0d", k, tx_q.size() - nb, en); end
      n_vec++; if (pack_tx(nb, en) !== ew) begin n_err++; $display("FAIL read_tx[%0d]: got %h want %h", k, pack_tx(nb, en), ew); end
      n_vec++; if (act_cyc - na != 2) begin n_err++; $display("FAIL read_active_cycles[%0d]: got %0d want 2", k, act_cyc - na); end
      for (int i = na; i < act_addr.size(); i++) begin
        n_vec++; if (act_addr[i] !== ea) begin n_err++; $display("FAIL read_addr[%0d]: got %h want %h", k, act_addr[i], ea); end
      end
      n_vec++; if (en_cyc - ne != 0 || wr_log.size() != nw) begin n_err++; $display("FAIL read_byte_en[%0d]: got %0d strobe cycles want 0", k, en_cyc - ne); end
    end
  endtask

  task automatic test_nak();
    byte_q_t p; bit done; int nb, na;
    logic [7:0] op;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) op = 8'h41;
      else do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
      p = {op};
      nb = tx_q.size(); na = act_cyc;
      exec_pkt(p, done);
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL nak_done[%0d]: got %0d want 1", k, done); end
      n_vec++; if (tx_q.size() - nb != 1 || pack_tx(nb, 1) !== 32'h1500_0000) begin
        n_err++; $display("FAIL nak_tx[%0d] op=%h: got %0d bytes %h want 1 byte 15", k, op, tx_q.size() - nb, pack_tx(nb, 1)); end
      n_vec++; if (act_cyc != na) begin n_err++; $display("FAIL nak_bus[%0d]: got %0d active cycles want 0", k, act_cyc - na); end
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t p; bit done; int nb, sb;
    bus_if.bus_rd = $urandom;
    p = mk_pkt(8'h52, $urandom, 32'h0);
    nb = tx_q.size(); sb = stop_bad;
    exec_pkt(p, done);
    n_vec++; if (done !== 1'b1 || tx_q.size() - nb != 4) begin n_err++; $display("FAIL b2b_len: got %0d bytes want 4", tx_q.size() - nb); end
    for (int i = 1; i < 4 && nb + i < tx_t.size(); i++) begin
      n_vec++; if (tx_t[nb + i] - tx_t[nb + i - 1] != 10 * DIV) begin
        n_err++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d", i, tx_t[nb + i] - tx_t[nb + i - 1], 10 * DIV); end
    end
    n_vec++; if (stop_bad != sb) begin n_err++; $display("FAIL b2b_stop: got %0d bad stop bits want 0", stop_bad - sb); end
  endtask

  task automatic test_timeout();
    byte_q_t p; bit done, ewr, erd; int en, nb, na;
    logic [31:0] rd, ew, ea, ed;
    nb = tx_q.size(); na = act_cyc;
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    repeat (TMO - 100) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL timeout_early: busy got %b want 1", busy); end
    repeat (150) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b want 0", busy); end
    n_vec++; if (tx_q.size() != nb || act_cyc != na) begin
      n_err++; $display("FAIL timeout_quiet: got %0d tx bytes %0d bus cycles want 0 0", tx_q.size() - nb, act_cyc - na); end
    rd = $urandom; bus_if.bus_rd = rd;
    p = mk_pkt(8'h52, $urandom, 32'h0);
    model(p, rd, en, ew, ewr, erd, ea, ed);
    nb = tx_q.size();
    exec_pkt(p, done);
    n_vec++; if (done !== 1'b1 || pack_tx(nb, en) !== ew) begin n_err++; $display("FAIL timeout_recover: got %h want %h", pack_tx(nb, en), ew); end
  endtask

  task automatic test_frame_error();
    byte_q_t p; bit done, ewr, erd; int en, nb, na, nw;
    logic [31:0] ew, ea, ed;
    nb = tx_q.size(); na = act_cyc;
    send_byte(8'h57, 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    repeat (2 * DIV) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL frame_busy: got %b want 0", busy); end
    repeat (12 * DIV) @(negedge clk);
    n_vec++; if (tx_q.size() != nb || act_cyc != na) begin
      n_err++; $display("FAIL frame_quiet: got %0d tx bytes %0d bus cycles want 0 0", tx_q.size() - nb, act_cyc - na); end
    p = mk_pkt(8'h57, $urandom, $urandom);
    model(p, 32'h0, en, ew, ewr, erd, ea, ed);
    nb = tx_q.size(); nw = wr_log.size();
    exec_pkt(p, done);
    n_vec++; if (done !== 1'b1 || pack_tx(nb, en) !== ew || wr_log.size() <= nw || wr_log[nw] !== {ea, ed}) begin
      n_err++; $display("FAIL frame_recover: got tx %h want %h", pack_tx(nb, en), ew); end
  endtask

  task automatic test_checksum();
`ifdef UART_LOADER_CHECKSUM_EN
    byte_q_t p; bit done, ewr, erd; int en, nb, nw;
    logic [31:0] ew, ea, ed;
    for (int k = 0; k < 2; k++) begin
      p = mk_pkt(8'h57, 32'h0000_0010, 32'h0000_0001);
      if (k == 1) p[p.size() - 1] = p[p.size() - 1] + 8'h01;
      model(p, 32'h0, en, ew, ewr, erd, ea, ed);
      nb = tx_q.size(); nw = wr_log.size();
      exec_pkt(p, done);
      n_vec++; if (done !== 1'b1 || pack_tx(nb, en) !== ew) begin n_err++; $display("FAIL sum_tx[%0d]: got %h want %h", k, pack_tx(nb, en), ew); end
      n_vec++; if (wr_log.size() - nw != (ewr ? 1 : 0)) begin n_err++; $display("FAIL sum_write[%0d]: got %0d writes want %0d", k, wr_log.size() - nw, ewr); end
    end
`endif
  endtask

  task automatic test_reset_mid_tx();
    byte_q_t p; bit seen;
    bus_if.bus_rd = 32'h0;
    p = mk_pkt(8'h52, 32'h0000_4444 | ($urandom & 32'hFFFF_0000), 32'h0);
    foreach (p[i]) send_byte(p[i], 1'b1);
    seen = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin seen = 1; break; end
    end
    repeat (DIV + DIV / 2) @(negedge clk);
    n_vec++; if (seen !== 1'b1 || uart_txd !== 1'b0) begin n_err++; $display("FAIL midtx_pre: got txd %b seen %0d want 0 1", uart_txd, seen); end
    sys_rstn = 1'b0;
    #1;
    n_vec++; if (uart_txd !== 1'b1) begin n_err++; $display("FAIL midtx_txd: got %b want 1", uart_txd); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midtx_busy: got %b want 0", busy); end
    n_vec++; if (bus_if.bus_addr !== 32'h0 || bus_if.bus_active !== 1'b0) begin
      n_err++; $display("FAIL midtx_bus: got addr %h active %b want 0 0", bus_if.bus_addr, bus_if.bus_active); end
    repeat (3) @(negedge clk);
    sys_rstn = 1'b1;
    repeat (12 * DIV) @(negedge clk);
  endtask

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no completion want finish within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.bus_rd = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_nak();
    test_back_to_back();
    test_timeout();
    test_frame_error();
    test_checksum();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
